// File: rtl/intersection_light_controller.sv
// -----------------------------------------------------------------------------
// intersection_light_controller
//
// Two-road intersection signal controller. The main road rests on green; the
// side road is served only when a vehicle sensor or pedestrian button request
// is pending. Every change of right-of-way passes through yellow and an
// all-red clearance. Emergency pre-emption favours the main road.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   side_req   in   side-road vehicle sensor (level or pulse)
//   ped_req    in   pedestrian crossing button (level or pulse)
//   emerg      in   emergency pre-emption, main-road priority (level)
//   main_light out  {R,Y,G} main road head, registered
//   side_light out  {R,Y,G} side road head, registered
//   ped_walk   out  walk indication for crossing the main road, registered
//   state_o    out  current state encoding (debug / checker visibility)
//   phase_done out  high in the first cycle of each new state
//
// State encoding: MAIN_G=0 MAIN_Y=1 ALL_R1=2 SIDE_G=3 SIDE_Y=4 ALL_R2=5.
// Codes 6/7 are illegal and fall back to ALL_R2 on the next edge.
// -----------------------------------------------------------------------------
module intersection_light_controller #(
  parameter int TIMER_W  = 6,
  parameter int MAIN_MIN = 8,
  parameter int MAIN_Y   = 3,
  parameter int CLR      = 2,
  parameter int SIDE_G   = 6,
  parameter int SIDE_Y   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       side_req,
  input  logic       ped_req,
  input  logic       emerg,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       ped_walk,
  output logic [2:0] state_o,
  output logic       phase_done
);

  localparam logic [2:0] S_MAIN_G = 3'd0;
  localparam logic [2:0] S_MAIN_Y = 3'd1;
  localparam logic [2:0] S_ALL_R1 = 3'd2;
  localparam logic [2:0] S_SIDE_G = 3'd3;
  localparam logic [2:0] S_SIDE_Y = 3'd4;
  localparam logic [2:0] S_ALL_R2 = 3'd5;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  // Last timer value of each phase: a phase of D cycles exits at timer == D-1.
  localparam logic [TIMER_W-1:0] MAIN_MIN_LAST = TIMER_W'(MAIN_MIN - 1);
  localparam logic [TIMER_W-1:0] MAIN_Y_LAST   = TIMER_W'(MAIN_Y - 1);
  localparam logic [TIMER_W-1:0] CLR_LAST      = TIMER_W'(CLR - 1);
  localparam logic [TIMER_W-1:0] SIDE_G_LAST   = TIMER_W'(SIDE_G - 1);
  localparam logic [TIMER_W-1:0] SIDE_Y_LAST   = TIMER_W'(SIDE_Y - 1);

  logic [2:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               side_pend_q, side_pend_d;
  logic               ped_pend_q, ped_pend_d;
  logic [2:0]         main_light_q, main_light_d;
  logic [2:0]         side_light_q, side_light_d;
  logic               ped_walk_q, ped_walk_d;
  logic               phase_done_q, phase_done_d;
  logic               enter_side;

  // State register (and all registered outputs, so lights track state_o).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_ALL_R2;
      timer_q      <= '0;
      side_pend_q  <= 1'b0;
      ped_pend_q   <= 1'b0;
      main_light_q <= L_RED;
      side_light_q <= L_RED;
      ped_walk_q   <= 1'b0;
      phase_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      side_pend_q  <= side_pend_d;
      ped_pend_q   <= ped_pend_d;
      main_light_q <= main_light_d;
      side_light_q <= side_light_d;
      ped_walk_q   <= ped_walk_d;
      phase_done_q <= phase_done_d;
    end
  end

  // Next-state, timer and request latches.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_MAIN_G: if ((timer_q >= MAIN_MIN_LAST) && (side_pend_q || ped_pend_q) && !emerg)
                  state_d = S_MAIN_Y;
      S_MAIN_Y: if (timer_q == MAIN_Y_LAST) state_d = S_ALL_R1;
      // Emergency at the end of clearance returns right-of-way to the main road.
      S_ALL_R1: if (timer_q == CLR_LAST) state_d = emerg ? S_MAIN_G : S_SIDE_G;
      S_SIDE_G: if (emerg || (timer_q == SIDE_G_LAST)) state_d = S_SIDE_Y;
      S_SIDE_Y: if (timer_q == SIDE_Y_LAST) state_d = S_ALL_R2;
      S_ALL_R2: if (timer_q == CLR_LAST) state_d = S_MAIN_G;
      default:  state_d = S_ALL_R2;
    endcase

    // Fixed phases exit at D-1, so only MAIN_G can sit long enough to wrap.
    if (state_d != state_q)
      timer_d = '0;
    else if ((state_q == S_MAIN_G) && (timer_q >= MAIN_MIN_LAST))
      timer_d = MAIN_MIN_LAST;
    else
      timer_d = timer_q + TIMER_W'(1);

    // A request seen on the entry edge survives the clear (set wins).
    enter_side  = (state_d == S_SIDE_G) && (state_q != S_SIDE_G);
    side_pend_d = side_req | (side_pend_q & ~enter_side);
    ped_pend_d  = ped_req  | (ped_pend_q  & ~enter_side);
  end

  // Output decode from the next state, registered on the same edge.
  always_comb begin
    main_light_d = L_RED;
    side_light_d = L_RED;
    case (state_d)
      S_MAIN_G: main_light_d = L_GRN;
      S_MAIN_Y: main_light_d = L_YEL;
      S_SIDE_G: side_light_d = L_GRN;
      S_SIDE_Y: side_light_d = L_YEL;
      default:  ;
    endcase

    // Walk is captured from the pending flag at SIDE_G entry and held there.
    if (state_d != S_SIDE_G)
      ped_walk_d = 1'b0;
    else if (state_q == S_SIDE_G)
      ped_walk_d = ped_walk_q;
    else
      ped_walk_d = ped_pend_q;

    phase_done_d = (state_d != state_q);
  end

  assign main_light = main_light_q;
  assign side_light = side_light_q;
  assign ped_walk   = ped_walk_q;
  assign state_o    = state_q;
  assign phase_done = phase_done_q;

endmodule

// File: doc/intersection_light_controller.md
Name: intersection_light_controller

Overview:
Parametrised two-road intersection controller; next generation of the single-road light sequencer.
- Drives the main-road and side-road signal heads {R,Y,G}.
- Main road rests on green; side road is served only on demand (vehicle sensor or pedestrian button).
- Adds all-red clearance, minimum main green, pedestrian walk and emergency pre-emption.

Parameters:
TIMER_W, 6, phase timer width in bits; every duration parameter must be in 1..2^TIMER_W
MAIN_MIN, 8, minimum main-green cycles before a pending request is served
MAIN_Y, 3, main-yellow cycles
CLR, 2, all-red clearance cycles
SIDE_G, 6, side-green cycles (fixed)
SIDE_Y, 3, side-yellow cycles

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
side_req  in  1  side-road vehicle sensor, level or pulse
ped_req  in  1  pedestrian crossing button, level or pulse
emerg  in  1  emergency pre-emption (main-road priority), level
main_light  out  3  {R,Y,G} main road, registered
side_light  out  3  {R,Y,G} side road, registered
ped_walk  out  1  walk indication for crossing the main road, registered
state_o  out  3  current state encoding
phase_done  out  1  one-cycle pulse on the cycle a state transition is taken

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (rst_n=0 at an edge):
  - state=ALL_R2, timer=0, side_pend=0, ped_pend=0
  - main_light=100, side_light=100, ped_walk=0, phase_done=0, state_o=5
  - Reset wins over every other input, including mid-phase.
- States and encodings:
  - MAIN_G=0: main 001, side 100
  - MAIN_Y=1: main 010, side 100
  - ALL_R1=2: both 100
  - SIDE_G=3: main 100, side 001
  - SIDE_Y=4: main 100, side 010
  - ALL_R2=5: both 100
  - Codes 6/7 are illegal and recover to ALL_R2 on the next edge.
- Timer:
  - Counts cycles spent in the current state, starting at 0.
  - Cleared to 0 on every transition.
  - A fixed-duration state of D cycles exits when timer==D-1, so it lasts exactly D cycles.
- Transitions:
  - MAIN_G -> MAIN_Y when timer>=MAIN_MIN-1 and (side_pend or ped_pend) and emerg=0.
  - MAIN_G otherwise holds; timer saturates at MAIN_MIN-1 (never wraps).
  - MAIN_Y -> ALL_R1 after MAIN_Y cycles.
  - ALL_R1 -> SIDE_G after CLR cycles. If emerg=1 on the exit cycle, go to MAIN_G instead; pendings are retained.
  - SIDE_G -> SIDE_Y after SIDE_G cycles, or on the next edge if emerg=1 (early abort).
  - SIDE_Y -> ALL_R2 after SIDE_Y cycles. Emergency does not shorten yellow or clearance.
  - ALL_R2 -> MAIN_G after CLR cycles.
- Requests:
  - side_pend is set by side_req=1 at any edge; ped_pend is set by ped_req=1 at any edge.
  - Both are cleared on the transition into SIDE_G.
  - Set takes priority over clear in the same cycle: a request asserted on the entry edge stays pending for the next cycle.
  - A request arriving during SIDE_G/SIDE_Y/ALL_R2 is served by a further cycle after MAIN_MIN.
- ped_walk:
  - Goes to 1 on entry to SIDE_G if ped_pend was set at that entry.
  - Held for the whole SIDE_G, and cleared on the SIDE_G exit edge, including an emergency abort.
- Outputs are registered and update on the same edge as state_o, so lights always match state_o.
- phase_done is registered and equals 1 in the first cycle of each new state.
- Never legal: both roads non-red simultaneously, or ped_walk=1 while main_light!=100. Both are bench assertions.

Test Plan:
1. Release rst_n, all inputs 0 -> 2 cycles state 5 (both 100), then MAIN_G (main 001) held for 50 cycles; phase_done pulses once.
2. side_req 1-cycle pulse in the 3rd MAIN_G cycle -> MAIN_G lasts 8 cycles total, then 1 (3 cycles), 2 (2), 3 (6, side 001), 4 (3), 5 (2), back to 0; ped_walk stays 0.
3. ped_req pulse only -> same sequence as scenario 2; ped_walk=1 for exactly the 6 SIDE_G cycles, 0 in SIDE_Y.
4. emerg raised in the 2nd SIDE_G cycle -> state 4 on the next edge, full 3-cycle yellow, 2-cycle all-red, MAIN_G; with emerg held, MAIN_G does not leave despite pending side_req.
5. rst_n low for one edge mid-SIDE_G with ped_walk=1 -> next cycle state 5, both lights 100, ped_walk=0, pendings cleared; no side service afterwards without a new request.
6. side_req held high continuously -> repeating cycle 8+3+2+6+3+2=24 cycles; side_pend re-latches during SIDE_G and each MAIN_G lasts exactly 8.
